// File: rtl/enigma_pkg.sv
// enigma_pkg -- shared types and constants for the Enigma UART sequencer.
//   state_t     : controller state encoding
//   ASCII_*     : ASCII code points used for letter classification
//   LETTER_W    : width of an alphabet index (0..25)
//   NUM_LETTERS : size of the alphabet
//   in_range()  : inclusive byte range test
// Build option: ENIGMA_ECHO_EN adds the ST_ECHO state.
package enigma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLASSIFY = 3'd1,
    ST_ENC_REQ  = 3'd2,
    ST_TX       = 3'd3,
`ifdef ENIGMA_ECHO_EN
    ST_STEP     = 3'd4,
    ST_ECHO     = 3'd5
`else
    ST_STEP     = 3'd4
`endif
  } state_t;

  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_a = 8'h61;
  localparam logic [7:0] ASCII_Z = 8'h5A;
  localparam logic [7:0] ASCII_z = 8'h7A;
  localparam logic [7:0] ASCII_Q = 8'h3F;

  localparam int LETTER_W    = 5;
  localparam int NUM_LETTERS = 26;

  function automatic logic in_range(input logic [7:0] b, input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (b >= lo) && (b <= hi);
  endfunction

endpackage

// File: rtl/enigma_seq_ctrl_map.sv
// ascii_letter_map -- purely combinational ASCII <-> alphabet index mapping.
//   i_byte       : ASCII byte to classify
//   o_is_letter  : byte is A..Z or a..z
//   o_lower      : byte is a..z
//   o_idx        : alphabet index 0..25 (0 for non-letters)
//   i_code       : cipher index to convert back to ASCII
//   i_code_lower : emit lowercase when set
//   o_ascii      : ASCII letter, or '?' when i_code is not a valid index
module ascii_letter_map
  import enigma_pkg::*;
(
  input  logic [7:0]          i_byte,
  output logic                o_is_letter,
  output logic                o_lower,
  output logic [LETTER_W-1:0] o_idx,
  input  logic [LETTER_W-1:0] i_code,
  input  logic                i_code_lower,
  output logic [7:0]          o_ascii
);

  logic w_upper;
  logic w_lower;

  // Classify the byte and derive its index within the alphabet.
  always_comb begin
    w_upper     = in_range(i_byte, ASCII_A, ASCII_Z);
    w_lower     = in_range(i_byte, ASCII_a, ASCII_z);
    o_is_letter = w_upper | w_lower;
    o_lower     = w_lower;
    if (w_lower) begin
      o_idx = LETTER_W'(i_byte - ASCII_a);
    end else if (w_upper) begin
      o_idx = LETTER_W'(i_byte - ASCII_A);
    end else begin
      o_idx = {LETTER_W{1'b0}};
    end
  end

  // The cipher core may return codes 26..31; those are shown as '?'.
  always_comb begin
    if (i_code >= LETTER_W'(NUM_LETTERS)) begin
      o_ascii = ASCII_Q;
    end else if (i_code_lower) begin
      o_ascii = ASCII_a + 8'(i_code);
    end else begin
      o_ascii = ASCII_A + 8'(i_code);
    end
  end

endmodule

// File: rtl/enigma_seq_ctrl.sv
// enigma_seq_ctrl -- sequencer between the UART byte interface and the Enigma
// cipher core. Letters are sent to the core over enc_req/enc_ack, the result is
// returned as ASCII on tx, and each encrypted letter is followed by a one-cycle
// rotor step pulse. Non-letters are passed through unchanged.
// Ports:
//   msclk, rst_n                : clock, synchronous active-low reset
//   rx_valid/rx_data/rx_ready   : received byte handshake
//   enc_req/enc_in/enc_ack/enc_out : cipher core request/response
//   step                        : rotor-advance pulse
//   tx_valid/tx_data/tx_ready   : byte-to-transmit handshake
//   busy, char_cnt, err         : status (not IDLE, encrypted count, sticky timeout)
// Build option: ENIGMA_ECHO_EN echoes each plaintext letter before its ciphertext.
module enigma_seq_ctrl
  import enigma_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 255,
  parameter bit UPPER_OUT = 1'b1
) (
  input  logic                msclk,
  input  logic                rst_n,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic                rx_ready,
  output logic                enc_req,
  output logic [LETTER_W-1:0] enc_in,
  input  logic                enc_ack,
  input  logic [LETTER_W-1:0] enc_out,
  output logic                step,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  input  logic                tx_ready,
  output logic                busy,
  output logic [CNT_W-1:0]    char_cnt,
  output logic                err
);

  // Counter runs 0..TIMEOUT-1 while waiting, so TIMEOUT request cycles in total.
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t                r_state, w_next_state;
  logic [7:0]            r_byte, w_byte_nx;
  logic                  r_lower, w_lower_nx;
  logic                  r_letter, w_letter_nx;
  logic [TO_W-1:0]       r_to_cnt, w_to_cnt_nx;
  logic [CNT_W-1:0]      r_char_cnt, w_cnt_nx;
  logic                  r_err, w_err_nx;
  logic [LETTER_W-1:0]   r_enc_in, w_enc_in_nx;
  logic [7:0]            r_tx_data, w_tx_data_nx;
  logic                  w_tx_valid_nx;
  logic                  r_rx_ready, r_enc_req, r_step, r_tx_valid, r_busy;

  logic                  w_map_letter, w_map_lower;
  logic [LETTER_W-1:0]   w_map_idx;
  logic [7:0]            w_map_ascii;

  ascii_letter_map u_map (
    .i_byte       (r_byte),
    .o_is_letter  (w_map_letter),
    .o_lower      (w_map_lower),
    .o_idx        (w_map_idx),
    .i_code       (enc_out),
    .i_code_lower ((UPPER_OUT == 1'b0) && r_lower),
    .o_ascii      (w_map_ascii)
  );

  // State register.
  always_ff @(posedge msclk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    w_next_state = r_state;
    w_byte_nx    = r_byte;
    w_lower_nx   = r_lower;
    w_letter_nx  = r_letter;
    w_to_cnt_nx  = r_to_cnt;
    w_cnt_nx     = r_char_cnt;
    w_err_nx     = r_err;
    w_enc_in_nx  = r_enc_in;
    w_tx_data_nx = r_tx_data;
    case (r_state)
      ST_IDLE: begin
        if (rx_valid && r_rx_ready) begin
          w_byte_nx    = rx_data;
          w_next_state = ST_CLASSIFY;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_CLASSIFY: begin
        w_lower_nx  = w_map_lower;
        w_letter_nx = w_map_letter;
        w_to_cnt_nx = {TO_W{1'b0}};
        if (w_map_letter) begin
          w_enc_in_nx  = w_map_idx;
`ifdef ENIGMA_ECHO_EN
          w_tx_data_nx = r_byte;
          w_next_state = ST_ECHO;
`else
          w_next_state = ST_ENC_REQ;
`endif
        end else begin
          w_tx_data_nx = r_byte;
          w_next_state = ST_TX;
        end
      end
`ifdef ENIGMA_ECHO_EN
      ST_ECHO: begin
        if (tx_ready) begin
          w_next_state = ST_ENC_REQ;
        end else begin
          w_next_state = ST_ECHO;
        end
      end
`endif
      ST_ENC_REQ: begin
        // An ack arriving on the last allowed cycle still wins over the timeout.
        if (enc_ack) begin
          w_tx_data_nx = w_map_ascii;
          w_next_state = ST_TX;
        end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
          w_err_nx     = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          w_to_cnt_nx  = r_to_cnt + TO_W'(1);
          w_next_state = ST_ENC_REQ;
        end
      end
      ST_TX: begin
        if (tx_ready) begin
          if (r_letter) begin
            // Count bumps together with the step pulse.
            w_cnt_nx     = r_char_cnt + CNT_W'(1);
            w_next_state = ST_STEP;
          end else begin
            w_next_state = ST_IDLE;
          end
        end else begin
          w_next_state = ST_TX;
        end
      end
      ST_STEP: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

`ifdef ENIGMA_ECHO_EN
    w_tx_valid_nx = (w_next_state == ST_TX) || (w_next_state == ST_ECHO);
`else
    w_tx_valid_nx = (w_next_state == ST_TX);
`endif
  end

  // Datapath and outputs, registered from the next state so they line up with it.
  always_ff @(posedge msclk) begin
    if (!rst_n) begin
      r_byte     <= 8'h00;
      r_lower    <= 1'b0;
      r_letter   <= 1'b0;
      r_to_cnt   <= {TO_W{1'b0}};
      r_char_cnt <= {CNT_W{1'b0}};
      r_err      <= 1'b0;
      r_enc_in   <= {LETTER_W{1'b0}};
      r_tx_data  <= 8'h00;
      r_rx_ready <= 1'b0;
      r_enc_req  <= 1'b0;
      r_step     <= 1'b0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_byte     <= w_byte_nx;
      r_lower    <= w_lower_nx;
      r_letter   <= w_letter_nx;
      r_to_cnt   <= w_to_cnt_nx;
      r_char_cnt <= w_cnt_nx;
      r_err      <= w_err_nx;
      r_enc_in   <= w_enc_in_nx;
      r_tx_data  <= w_tx_data_nx;
      r_rx_ready <= (w_next_state == ST_IDLE);
      r_enc_req  <= (w_next_state == ST_ENC_REQ);
      r_step     <= (w_next_state == ST_STEP);
      r_tx_valid <= w_tx_valid_nx;
      r_busy     <= (w_next_state != ST_IDLE);
    end
  end

  assign rx_ready = r_rx_ready;
  assign enc_req  = r_enc_req;
  assign enc_in   = r_enc_in;
  assign step     = r_step;
  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
  assign busy     = r_busy;
  assign char_cnt = r_char_cnt;
  assign err      = r_err;

endmodule

// File: tb/tb_enigma_seq_ctrl.sv
// tb_enigma_seq_ctrl -- directed self-checking bench for enigma_seq_ctrl.
// Two instances share all inputs: dut_a (uppercase output) and dut_b (case kept),
// both with an 8-cycle request timeout. Compile with ENIGMA_ECHO_EN to cover echo.
module tb_enigma_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n    = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       enc_ack  = 1'b0;
  logic [4:0] enc_out  = 5'd0;
  logic       tx_ready = 1'b1;

  logic        a_rx_ready, a_enc_req, a_step, a_tx_valid, a_busy, a_err;
  logic [4:0]  a_enc_in;
  logic [7:0]  a_tx_data;
  logic [15:0] a_char_cnt;
  logic        b_rx_ready, b_enc_req, b_step, b_tx_valid, b_busy, b_err;
  logic [4:0]  b_enc_in;
  logic [7:0]  b_tx_data;
  logic [15:0] b_char_cnt;

  enigma_seq_ctrl #(.CNT_W(16), .TIMEOUT(8), .UPPER_OUT(1'b1)) dut_a (
    .msclk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(a_rx_ready), .enc_req(a_enc_req), .enc_in(a_enc_in),
    .enc_ack(enc_ack), .enc_out(enc_out), .step(a_step), .tx_valid(a_tx_valid),
    .tx_data(a_tx_data), .tx_ready(tx_ready), .busy(a_busy),
    .char_cnt(a_char_cnt), .err(a_err)
  );

  enigma_seq_ctrl #(.CNT_W(16), .TIMEOUT(8), .UPPER_OUT(1'b0)) dut_b (
    .msclk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(b_rx_ready), .enc_req(b_enc_req), .enc_in(b_enc_in),
    .enc_ack(enc_ack), .enc_out(enc_out), .step(b_step), .tx_valid(b_tx_valid),
    .tx_data(b_tx_data), .tx_ready(tx_ready), .busy(b_busy),
    .char_cnt(b_char_cnt), .err(b_err)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_cnt  = 16'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, ":rx_ready"}, {a_rx_ready, b_rx_ready}, 32'd0);
    check_eq({tag, ":enc_req"},  {a_enc_req, b_enc_req}, 32'd0);
    check_eq({tag, ":enc_in"},   {a_enc_in, b_enc_in}, 32'd0);
    check_eq({tag, ":step"},     {a_step, b_step}, 32'd0);
    check_eq({tag, ":tx_valid"}, {a_tx_valid, b_tx_valid}, 32'd0);
    check_eq({tag, ":tx_data"},  {a_tx_data, b_tx_data}, 32'd0);
    check_eq({tag, ":busy"},     {a_busy, b_busy}, 32'd0);
    check_eq({tag, ":char_cnt"}, {a_char_cnt, b_char_cnt}, 32'd0);
    check_eq({tag, ":err"},      {a_err, b_err}, 32'd0);
  endtask

  // One byte through the controller with an immediate ack and tx_ready high.
  task automatic do_char(input string tag, input logic [7:0] b, input bit letter,
                         input logic [4:0] idx, input logic [4:0] eo,
                         input logic [7:0] exp_a, input logic [7:0] exp_b);
    check_eq({tag, ":ready"}, {a_rx_ready, b_rx_ready}, 32'd3);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    check_eq({tag, ":classify"}, {a_busy, a_rx_ready, a_tx_valid, a_enc_req}, 32'h8);
    @(negedge clk);
`ifdef ENIGMA_ECHO_EN
    if (letter) begin
      check_eq({tag, ":echo_valid"}, {a_tx_valid, b_tx_valid}, 32'd3);
      check_eq({tag, ":echo_data"}, a_tx_data, {24'd0, b});
      @(negedge clk);
    end
`endif
    if (letter) begin
      check_eq({tag, ":enc_req"}, {a_enc_req, b_enc_req}, 32'd3);
      check_eq({tag, ":enc_in"}, a_enc_in, {27'd0, idx});
      enc_ack = 1'b1;
      enc_out = eo;
      @(negedge clk);
      enc_ack = 1'b0;
      enc_out = 5'd0;
    end else begin
      check_eq({tag, ":no_req"}, {a_enc_req, b_enc_req}, 32'd0);
    end
    check_eq({tag, ":tx_valid"}, {a_tx_valid, b_tx_valid}, 32'd3);
    check_eq({tag, ":tx_data_a"}, a_tx_data, {24'd0, exp_a});
    check_eq({tag, ":tx_data_b"}, b_tx_data, {24'd0, exp_b});
    check_eq({tag, ":no_step_tx"}, {a_step, b_step}, 32'd0);
    @(negedge clk);
    if (letter) begin
      exp_cnt = exp_cnt + 16'd1;
      check_eq({tag, ":step"}, {a_step, b_step, a_tx_valid}, 32'd6);
      check_eq({tag, ":cnt_step"}, a_char_cnt, {16'd0, exp_cnt});
      @(negedge clk);
    end
    check_eq({tag, ":idle"}, {a_step, a_tx_valid, a_rx_ready, a_busy}, 32'h2);
    check_eq({tag, ":cnt_a"}, a_char_cnt, {16'd0, exp_cnt});
    check_eq({tag, ":cnt_b"}, b_char_cnt, {16'd0, exp_cnt});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  req_cycles;
    bit  seen_tx;
    bit  seen_step;
    int  stable;

    // Reset values.
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset_ready", {a_rx_ready, b_rx_ready}, 32'd3);

    // Directed vectors: tag, byte, letter, idx, enc_out, expected A, expected B.
    do_char("A",     8'h41, 1'b1, 5'd0,  5'd1,  8'h42, 8'h42);
    do_char("c",     8'h63, 1'b1, 5'd2,  5'd4,  8'h45, 8'h65);
    do_char("space", 8'h20, 1'b0, 5'd0,  5'd0,  8'h20, 8'h20);
    do_char("z",     8'h7A, 1'b1, 5'd25, 5'd25, 8'h5A, 8'h7A);
    do_char("Z_bad", 8'h5A, 1'b1, 5'd25, 5'd30, 8'h3F, 8'h3F);
    do_char("at",    8'h40, 1'b0, 5'd0,  5'd0,  8'h40, 8'h40);
    do_char("lbrk",  8'h5B, 1'b0, 5'd0,  5'd0,  8'h5B, 8'h5B);
    do_char("btick", 8'h60, 1'b0, 5'd0,  5'd0,  8'h60, 8'h60);
    do_char("lbrc",  8'h7B, 1'b0, 5'd0,  5'd0,  8'h7B, 8'h7B);
    do_char("a",     8'h61, 1'b1, 5'd0,  5'd0,  8'h41, 8'h61);
    do_char("H",     8'h48, 1'b1, 5'd7,  5'd0,  8'h41, 8'h41);

    // Timeout: ack held low; expect exactly 8 request cycles, then sticky err.
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    @(negedge clk);
    rx_valid   = 1'b0;
    req_cycles = 0;
    seen_tx    = 1'b0;
    seen_step  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_step || b_step) seen_step = 1'b1;
      if (a_enc_req) begin
        req_cycles++;
      end else if (req_cycles > 0) begin
        break;
      end
      if (req_cycles > 0 && (a_tx_valid || b_tx_valid)) seen_tx = 1'b1;
    end
    check_eq("to_req_cycles", req_cycles, 32'd8);
    check_eq("to_err", {a_err, b_err}, 32'd3);
    check_eq("to_no_tx", {31'd0, seen_tx}, 32'd0);
    check_eq("to_no_step", {31'd0, seen_step}, 32'd0);
    check_eq("to_idle", {a_rx_ready, a_busy}, 32'd2);
    check_eq("to_cnt", a_char_cnt, {16'd0, exp_cnt});
    do_char("after_to", 8'h41, 1'b1, 5'd0, 5'd1, 8'h42, 8'h42);
    check_eq("err_sticky", {a_err, b_err}, 32'd3);

    // TX stall for 20 cycles, then reset mid-transfer.
    rx_valid = 1'b1;
    rx_data  = 8'h44;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
`ifdef ENIGMA_ECHO_EN
    @(negedge clk);
`endif
    enc_ack  = 1'b1;
    enc_out  = 5'd1;
    tx_ready = 1'b0;
    @(negedge clk);
    enc_ack   = 1'b0;
    stable    = 0;
    seen_step = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (a_tx_valid && (a_tx_data == 8'h42) && (b_tx_data == 8'h42) && !a_rx_ready)
        stable++;
      if (a_step || b_step) seen_step = 1'b1;
      @(negedge clk);
    end
    check_eq("stall_stable", stable, 32'd20);
    check_eq("stall_enc_in", a_enc_in, 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("mid_reset");
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    exp_cnt  = 16'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (a_step || b_step || a_tx_valid) seen_step = 1'b1;
    end
    check_eq("reset_no_step_tx", {31'd0, seen_step}, 32'd0);
    check_eq("reset_err_clear", {a_err, b_err}, 32'd0);
    do_char("recover", 8'h63, 1'b1, 5'd2, 5'd4, 8'h45, 8'h65);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
